// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rv32_pkg: RV32I opcodes, forwarding mux codes and hazard FSM states
// shared by the hazard controller slice.
package rv32_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIR_WAIT} state_t;
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_REG};
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status in, stage-register control out.
// HAZARD_PERF_CNT_EN adds the stall_cnt/flush_cnt performance counters.
interface pipeline_hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, mem_reg_write, wb_reg_write;
  logic       ex_br_taken, imem_ready, dmem_req, dmem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, bus_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif
  modport master (
    output id_op, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           ex_mem_read, mem_reg_write, wb_reg_write,
           ex_br_taken, imem_ready, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel,
           if_id_flush, id_ex_flush, mem_wb_flush, bus_err, fwd_a, fwd_b
`ifdef HAZARD_PERF_CNT_EN
    , stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input  id_op, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           ex_mem_read, mem_reg_write, wb_reg_write,
           ex_br_taken, imem_ready, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel,
           if_id_flush, id_ex_flush, mem_wb_flush, bus_err, fwd_a, fwd_b
`ifdef HAZARD_PERF_CNT_EN
    , stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// hazard_fwd_unit: EX operand forwarding select and load-use detection,
// purely combinational; x0 is never forwarded or treated as a hazard.
module hazard_fwd_unit
  import rv32_pkg::*;
(
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       ex_mem_read,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use
);
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mw, input logic [4:0] md,
                                         input logic ww, input logic [4:0] wd);
    return (mw && md != '0 && md == rs) ? FWD_EXMEM : (ww && wd != '0 && wd == rs) ? FWD_MEMWB : FWD_RF;
  endfunction
  assign fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  assign fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  assign load_use = ex_mem_read && ex_rd != '0 &&
                    ((uses_rs1(id_op) && ex_rd == id_rs1) || (uses_rs2(id_op) && ex_rd == id_rs2));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage RV32I sequencer (stalls, flushes, forwarding, dmem timeout).
// HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs of width CNT_W.
module pipeline_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  state_t      state_q, state_d, eff;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        load_use, miss, tmo, freeze;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, pc_sel, if_id_flush, id_ex_flush, mem_wb_flush;
  hazard_fwd_unit u_fwd (
    .id_op(bus.id_op), .id_rs1(bus.id_rs1), .id_rs2(bus.id_rs2),
    .ex_rs1(bus.ex_rs1), .ex_rs2(bus.ex_rs2), .ex_rd(bus.ex_rd),
    .mem_rd(bus.mem_rd), .wb_rd(bus.wb_rd), .ex_mem_read(bus.ex_mem_read),
    .mem_reg_write(bus.mem_reg_write), .wb_reg_write(bus.wb_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use)
  );
  // A releasing MEM_WAIT cycle behaves like the state it will return to, so a held branch is not lost.
  always_comb begin
    miss         = bus.dmem_req && !bus.dmem_ready;
    tmo          = state_q == MEM_WAIT && cnt_q == 16'(DMEM_TIMEOUT - 1) && !bus.dmem_ready;
    freeze       = state_q == MEM_WAIT ? !bus.dmem_ready && !tmo : miss;
    eff          = state_q == MEM_WAIT ? (pend_q ? REDIR_WAIT : RUN) : state_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    pc_sel       = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = RUN;
    cnt_d        = '0;
    pend_d       = 1'b0;
    if (freeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      mem_wb_flush = 1'b1;
      state_d      = MEM_WAIT;
      cnt_d        = state_q == MEM_WAIT ? cnt_q + 16'd1 : '0;
      pend_d       = state_q == MEM_WAIT ? pend_q : state_q == REDIR_WAIT;
    end else if (eff == REDIR_WAIT) begin
      pc_en       = bus.imem_ready;
      if_id_flush = 1'b1;
      state_d     = bus.imem_ready ? RUN : REDIR_WAIT;
    end else if (bus.ex_br_taken) begin
      pc_sel      = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = bus.imem_ready ? RUN : REDIR_WAIT;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_en       = bus.imem_ready;
      if_id_flush = !bus.imem_ready;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (pc_sel && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
`ifdef HAZARD_PERF_CNT_EN
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end
  // While reset is low the outputs show the idle RUN pattern regardless of inputs.
  assign bus.pc_en        = pc_en | ~rst_n;
  assign bus.if_id_en     = if_id_en | ~rst_n;
  assign bus.id_ex_en     = id_ex_en | ~rst_n;
  assign bus.ex_mem_en    = ex_mem_en | ~rst_n;
  assign bus.pc_sel       = pc_sel & rst_n;
  assign bus.if_id_flush  = if_id_flush & rst_n;
  assign bus.id_ex_flush  = id_ex_flush & rst_n;
  assign bus.mem_wb_flush = mem_wb_flush & rst_n;
  assign bus.bus_err      = tmo & rst_n;
  assign bus.fwd_a        = rst_n ? fwd_a : FWD_RF;
  assign bus.fwd_b        = rst_n ? fwd_b : FWD_RF;
endmodule
